// File: rtl/index_codec_pkg.sv
// Shared helpers for the index codec blocks (decoder now, encoder later).
//
// Functions work on a fixed MAX_W-wide vector so they can serve any block
// width up to MAX_W. Callers zero-extend their operands and take the low
// bits of the result.
//   onehot_decode(idx, width) : {err, vec}; vec has bit idx set when
//                               idx < width, otherwise vec = 0 and err = 1
//   popcount(v)               : number of set bits in v
//   lowest_set(v)             : priority encode, index of the lowest set bit
package index_codec_pkg;

  localparam int MAX_W = 256;

  typedef struct packed {
    logic             err;
    logic [MAX_W-1:0] vec;
  } decode_t;

  function automatic decode_t onehot_decode(input int unsigned idx,
                                            input int unsigned width);
    decode_t r;
    r.err = 1'b0;
    r.vec = '0;
    if (idx >= width) r.err = 1'b1;
    else              r.vec = MAX_W'(1) << idx;
    return r;
  endfunction

  function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_W; i++) cnt = cnt + {31'b0, v[i]};
    return cnt;
  endfunction

  function automatic int unsigned lowest_set(input logic [MAX_W-1:0] v);
    int unsigned r;
    logic        found;
    r     = 0;
    found = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (v[i] && !found) begin
        r     = i;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/index_decoder_accum_stage.sv
// One-entry valid/ready register stage, generic over payload width.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A producer holding valid must keep its data stable until that
// edge. in_ready = !out_valid || out_ready, so a held item can be replaced
// in the same cycle it leaves (no bubble on back-to-back streams).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     upstream handshake
//   in_data               payload captured on accept
//   out_valid/out_ready   downstream handshake
//   out_data              held payload, stable while out_valid && !out_ready
module index_decoder_accum_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/index_decoder_accum.sv
// Streaming index-to-one-hot decoder with a running accumulated mask.
//
// Each accepted index is decoded to a one-hot and presented one cycle later
// through a one-entry valid/ready stage. The decode is also folded into a
// mask (OR or replace, selected by in_accum); a registered population count
// of the mask is kept alongside it.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     index handshake (transfer when both are 1)
//   in_index              binary index, sampled only on accept
//   in_accum              1: mask |= decode, 0: mask = decode
//   clear                 synchronous mask clear, ordered before the decode
//   out_valid/out_ready   output handshake
//   out_onehot, out_err   decode of the held item; err when index >= width
//   mask, mask_count      accumulated mask and its set-bit count
module index_decoder_accum
  import index_codec_pkg::*;
#(
  parameter  int OUTPUT_WIDTH = 8,
  localparam int IDX_W        = $clog2(OUTPUT_WIDTH),
  localparam int CNT_W        = $clog2(OUTPUT_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IDX_W-1:0]        in_index,
  input  logic                    in_accum,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_onehot,
  output logic                    out_err,
  output logic [OUTPUT_WIDTH-1:0] mask,
  output logic [CNT_W-1:0]        mask_count
);

  localparam int PAY_W = 1 + IDX_W + OUTPUT_WIDTH;

  decode_t                 dec;
  logic [OUTPUT_WIDTH-1:0] dec_vec;
  logic                    dec_err;
  logic                    accept;
  logic [PAY_W-1:0]        pay_in;
  logic [PAY_W-1:0]        pay_out;
  logic [IDX_W-1:0]        out_idx;
  logic [OUTPUT_WIDTH-1:0] mask_next;

  assign dec     = onehot_decode(32'(in_index), OUTPUT_WIDTH);
  assign dec_vec = dec.vec[OUTPUT_WIDTH-1:0];
  assign dec_err = dec.err;

  // The held index travels with the decode so the one-hot can be
  // cross-checked against what was actually accepted.
  assign pay_in = {dec_err, in_index, dec_vec};

  index_decoder_accum_stage #(
    .PAYLOAD_W (PAY_W)
  ) u_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_out)
  );

  assign {out_err, out_idx, out_onehot} = pay_out;

  assign accept = in_valid && in_ready;

  // Clear is ordered before the decode: when both happen, the mask ends up
  // as the decode alone regardless of in_accum. Erroring indices leave the
  // (possibly cleared) mask untouched.
  always_comb begin
    mask_next = mask;
    if (clear) mask_next = '0;
    if (accept && !dec_err) begin
      if (in_accum && !clear) mask_next = mask | dec_vec;
      else                    mask_next = dec_vec;
    end
  end

  // The count is computed from mask_next so both registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask       <= '0;
      mask_count <= '0;
    end else begin
      mask       <= mask_next;
      mask_count <= CNT_W'(popcount(MAX_W'(mask_next)));
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && !out_err) begin
        assert ($countones(out_onehot) == 1);
        assert (lowest_set(MAX_W'(out_onehot)) == 32'(out_idx));
        assert (32'(mask_count) == $countones(mask));
      end
      // Decode must never produce bits above the block width.
      if (in_valid) assert ((dec.vec >> OUTPUT_WIDTH) == '0);
    end
  end

endmodule

// File: tb/tb_index_decoder_accum.sv
module tb_index_decoder_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // W=8 instance
  logic       v8, r8, a8, c8, ov8, or8, e8;
  logic [2:0] i8;
  logic [7:0] oh8, m8;
  logic [3:0] mc8;
  // W=5 instance
  logic       v5, r5, a5, c5, ov5, or5, e5;
  logic [2:0] i5, mc5;
  logic [4:0] oh5, m5;
  // W=2 instance
  logic       v2, r2, a2, c2, ov2, or2, e2;
  logic [0:0] i2;
  logic [1:0] oh2, m2, mc2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  index_decoder_accum #(.OUTPUT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_index(i8),
    .in_accum(a8), .clear(c8), .out_valid(ov8), .out_ready(or8),
    .out_onehot(oh8), .out_err(e8), .mask(m8), .mask_count(mc8));

  index_decoder_accum #(.OUTPUT_WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(r5), .in_index(i5),
    .in_accum(a5), .clear(c5), .out_valid(ov5), .out_ready(or5),
    .out_onehot(oh5), .out_err(e5), .mask(m5), .mask_count(mc5));

  index_decoder_accum #(.OUTPUT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_index(i2),
    .in_accum(a2), .clear(c2), .out_valid(ov2), .out_ready(or2),
    .out_onehot(oh2), .out_err(e2), .mask(m2), .mask_count(mc2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    v8 = 0; i8 = '0; a8 = 0; c8 = 0; or8 = 0;
    v5 = 0; i5 = '0; a5 = 0; c5 = 0; or5 = 0;
    v2 = 0; i2 = '0; a2 = 0; c2 = 0; or2 = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    n_checks++; if ({ov8, oh8, e8, m8, mc8} !== '0) begin n_fail++; $display("FAIL reset_w8: got ov=%0b oh=%h err=%0b mask=%h cnt=%0d want all 0", ov8, oh8, e8, m8, mc8); end
    n_checks++; if ({ov5, oh5, e5, m5, mc5} !== '0) begin n_fail++; $display("FAIL reset_w5: got ov=%0b oh=%h err=%0b mask=%h cnt=%0d want all 0", ov5, oh5, e5, m5, mc5); end
    n_checks++; if ({ov2, oh2, e2, m2, mc2} !== '0) begin n_fail++; $display("FAIL reset_w2: got ov=%0b oh=%h err=%0b mask=%h cnt=%0d want all 0", ov2, oh2, e2, m2, mc2); end
    rst = 1'b0;
    tick();
    n_checks++; if ({r8, r5, r2} !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b want 111", {r8, r5, r2}); end
  endtask

  task automatic test_single;
    do_reset();
    or8 = 1; v8 = 1; i8 = 3'd5; a8 = 1;
    tick();
    v8 = 0;
    n_checks++; if (ov8 !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", ov8); end
    n_checks++; if (oh8 !== 8'b0010_0000) begin n_fail++; $display("FAIL single_onehot: got %b want 00100000", oh8); end
    n_checks++; if (m8 !== 8'b0010_0000 || mc8 !== 4'd1) begin n_fail++; $display("FAIL single_mask: got %b/%0d want 00100000/1", m8, mc8); end
    tick();
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %0b want 0", ov8); end
  endtask

  task automatic test_back_to_back;
    int idxs[4] = '{0, 3, 3, 7};
    do_reset();
    or8 = 1; a8 = 1;
    foreach (idxs[k]) begin
      v8 = 1; i8 = 3'(idxs[k]);
      #1;
      n_checks++; if (r8 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b want 1", k, r8); end
      tick();
      n_checks++; if (ov8 !== 1'b1 || oh8 !== 8'(1 << idxs[k])) begin n_fail++; $display("FAIL b2b_out[%0d]: got v=%0b oh=%b want v=1 oh=%b", k, ov8, oh8, 8'(1 << idxs[k])); end
    end
    v8 = 0;
    n_checks++; if (m8 !== 8'b1000_1001 || mc8 !== 4'd3) begin n_fail++; $display("FAIL b2b_mask: got %b/%0d want 10001001/3", m8, mc8); end
    tick();
  endtask

  task automatic test_backpressure;
    do_reset();
    or8 = 0; v8 = 1; i8 = 3'd2; a8 = 1;
    tick();
    i8 = 3'd6;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (r8 !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %0b want 0", k, r8); end
      n_checks++; if (ov8 !== 1'b1 || oh8 !== 8'b0000_0100) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%0b oh=%b want v=1 oh=00000100", k, ov8, oh8); end
      tick();
    end
    or8 = 1;
    #1;
    n_checks++; if (r8 !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b want 1", r8); end
    tick();
    v8 = 0;
    n_checks++; if (ov8 !== 1'b1 || oh8 !== 8'b0100_0000) begin n_fail++; $display("FAIL bp_second: got v=%0b oh=%b want v=1 oh=01000000", ov8, oh8); end
    tick();
    n_checks++; if (ov8 !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %0b want 0", ov8); end
    n_checks++; if (m8 !== 8'h44 || mc8 !== 4'd2) begin n_fail++; $display("FAIL bp_mask: got %h/%0d want 44/2", m8, mc8); end
  endtask

  task automatic test_out_of_range;
    do_reset();
    or5 = 1; v5 = 1; a5 = 1; i5 = 3'd1;
    tick();
    n_checks++; if (oh5 !== 5'b00010 || m5 !== 5'b00010) begin n_fail++; $display("FAIL oor_seed: got oh=%b mask=%b want 00010/00010", oh5, m5); end
    i5 = 3'd6;
    tick();
    n_checks++; if (ov5 !== 1'b1 || e5 !== 1'b1 || oh5 !== 5'b0) begin n_fail++; $display("FAIL oor_err6: got v=%0b err=%0b oh=%b want 1/1/00000", ov5, e5, oh5); end
    n_checks++; if (m5 !== 5'b00010 || mc5 !== 3'd1) begin n_fail++; $display("FAIL oor_mask6: got %b/%0d want 00010/1", m5, mc5); end
    i5 = 3'd7; a5 = 0;
    tick();
    n_checks++; if (e5 !== 1'b1 || m5 !== 5'b00010) begin n_fail++; $display("FAIL oor_err7_replace: got err=%0b mask=%b want 1/00010", e5, m5); end
    i5 = 3'd4; a5 = 1;
    tick();
    v5 = 0;
    n_checks++; if (e5 !== 1'b0 || oh5 !== 5'b10000) begin n_fail++; $display("FAIL oor_idx4: got err=%0b oh=%b want 0/10000", e5, oh5); end
    n_checks++; if (m5 !== 5'b10010 || mc5 !== 3'd2) begin n_fail++; $display("FAIL oor_mask4: got %b/%0d want 10010/2", m5, mc5); end
    tick();
  endtask

  task automatic test_clear_replace;
    do_reset();
    or8 = 1; v8 = 1; a8 = 1;
    for (int k = 0; k < 8; k++) begin
      i8 = 3'(k);
      tick();
    end
    n_checks++; if (m8 !== 8'hFF || mc8 !== 4'd8) begin n_fail++; $display("FAIL clr_full: got %h/%0d want ff/8", m8, mc8); end
    c8 = 1; i8 = 3'd1; a8 = 1;
    tick();
    n_checks++; if (m8 !== 8'h02 || mc8 !== 4'd1) begin n_fail++; $display("FAIL clr_with_accept: got %h/%0d want 02/1", m8, mc8); end
    c8 = 0; a8 = 0; i8 = 3'd6;
    tick();
    n_checks++; if (m8 !== 8'h40 || mc8 !== 4'd1) begin n_fail++; $display("FAIL clr_replace: got %h/%0d want 40/1", m8, mc8); end
    v8 = 0; c8 = 1;
    tick();
    c8 = 0;
    n_checks++; if (m8 !== 8'h00 || mc8 !== 4'd0) begin n_fail++; $display("FAIL clr_only: got %h/%0d want 00/0", m8, mc8); end
  endtask

  task automatic test_async_reset;
    do_reset();
    or8 = 0; v8 = 1; i8 = 3'd3; a8 = 1;
    or2 = 0; v2 = 1; i2 = 1'b1; a2 = 1;
    tick();
    v8 = 0; v2 = 0;
    n_checks++; if (ov8 !== 1'b1 || ov2 !== 1'b1) begin n_fail++; $display("FAIL ar_held: got %0b%0b want 11", ov8, ov2); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({ov8, oh8, e8, m8, mc8} !== '0) begin n_fail++; $display("FAIL ar_w8_immediate: got ov=%0b oh=%h mask=%h cnt=%0d want 0", ov8, oh8, m8, mc8); end
    n_checks++; if ({ov2, oh2, e2, m2, mc2} !== '0) begin n_fail++; $display("FAIL ar_w2_immediate: got ov=%0b oh=%b mask=%b cnt=%0d want 0", ov2, oh2, m2, mc2); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (r8 !== 1'b1 || r2 !== 1'b1 || ov8 !== 1'b0) begin n_fail++; $display("FAIL ar_release: got r8=%0b r2=%0b ov8=%0b want 1/1/0", r8, r2, ov8); end
    or2 = 1; v2 = 1; a2 = 1; i2 = 1'b0;
    tick();
    n_checks++; if (oh2 !== 2'b01) begin n_fail++; $display("FAIL w2_idx0: got %b want 01", oh2); end
    i2 = 1'b1;
    tick();
    v2 = 0;
    n_checks++; if (oh2 !== 2'b10 || m2 !== 2'b11 || mc2 !== 2'd2) begin n_fail++; $display("FAIL w2_idx1: got oh=%b mask=%b cnt=%0d want 10/11/2", oh2, m2, mc2); end
  endtask

  // Randomized W=8 run against a spec-level model: integer mask arithmetic,
  // one held item, and a queue of decodes that must leave in accept order.
  task automatic test_random;
    int         mm_mask;
    logic       m_ov;
    logic [7:0] m_oh, dec, exp_item;
    logic       exp_ready, acc;
    do_reset();
    exp_q.delete();
    mm_mask = 0; m_ov = 0; m_oh = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_checks++; if (ov8 !== m_ov) begin n_fail++; $display("FAIL rnd_valid@%0d: got %0b want %0b", cyc, ov8, m_ov); end
      if (m_ov) begin
        n_checks++; if (oh8 !== m_oh || e8 !== 1'b0) begin n_fail++; $display("FAIL rnd_onehot@%0d: got %b/%0b want %b/0", cyc, oh8, e8, m_oh); end
      end
      n_checks++; if (m8 !== 8'(mm_mask) || 32'(mc8) != $countones(8'(mm_mask))) begin n_fail++; $display("FAIL rnd_mask@%0d: got %h/%0d want %h/%0d", cyc, m8, mc8, 8'(mm_mask), $countones(8'(mm_mask))); end
      v8  = ($urandom_range(0, 3) != 0);
      i8  = v8 ? 3'($urandom_range(0, 7)) : 3'bx;
      a8  = ($urandom_range(0, 3) != 0);
      c8  = ($urandom_range(0, 15) == 0);
      or8 = ($urandom_range(0, 2) != 0);
      #1;
      exp_ready = !m_ov || or8;
      n_checks++; if (r8 !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d: got %0b want %0b", cyc, r8, exp_ready); end
      if (ov8 && or8) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_extra_item@%0d: got %b want none", cyc, oh8); end
        else begin
          exp_item = exp_q.pop_front();
          if (oh8 !== exp_item) begin n_fail++; $display("FAIL rnd_order@%0d: got %b want %b", cyc, oh8, exp_item); end
        end
      end
      acc = v8 && exp_ready;
      dec = acc ? 8'(1) << i8 : 8'h00;
      if (c8) mm_mask = 0;
      if (acc) begin
        exp_q.push_back(dec);
        mm_mask = (a8 && !c8) ? (mm_mask | int'(dec)) : int'(dec);
        m_ov = 1'b1;
        m_oh = dec;
      end else if (m_ov && or8) begin
        m_ov = 1'b0;
      end
      tick();
    end
    n_checks++; if (exp_q.size() != (m_ov ? 1 : 0)) begin n_fail++; $display("FAIL rnd_leftover: got %0d queued want %0d", exp_q.size(), m_ov ? 1 : 0); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_clear_replace();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/index_decoder_accum.md
Name: index_decoder_accum

Overview:
Sequential inverse of the priority encoder. Accepts a stream of binary indices on a valid/ready handshake and decodes each index to a one-hot vector. Each one-hot is also folded into a running bitmask, so downstream logic sees both the per-item decode and the set of indices seen so far. It sits between an index producer (for example, an encoder or scheduler) and a bitmap consumer, with one registered output stage.

Parameters:
OUTPUT_WIDTH, 8, number of decoded lines; legal range is 2 and up, and non-powers of two are allowed.
IDX_W, $clog2(OUTPUT_WIDTH), derived index width; localparam, not overridable.
CNT_W, $clog2(OUTPUT_WIDTH+1), derived population-count width; localparam.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  an index is presented.
in_ready  output  1  the block can accept an index this cycle.
in_index  input  IDX_W  binary index to decode.
in_accum  input  1  1 = OR the decode into the mask; 0 = replace the mask with the decode.
clear  input  1  synchronous clear of the mask.
out_valid  output  1  the output registers hold an item.
out_ready  input  1  downstream accepts the item.
out_onehot  output  OUTPUT_WIDTH  decoded one-hot for the held item.
out_err  output  1  the held item's index is >= OUTPUT_WIDTH.
mask  output  OUTPUT_WIDTH  running accumulated mask.
mask_count  output  CNT_W  number of set bits in mask.

Behaviour:
- Reset (async assert): out_valid=0, out_onehot=0, out_err=0, mask=0, mask_count=0. in_ready is 1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; one-entry pipe with no bubble on back-to-back transfers).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_onehot and out_err hold stable.
- Latency: an index accepted in cycle N appears on out_* in cycle N+1.
- Decode:
  - Legal index: out_onehot = 1 << in_index and out_err=0.
  - Index >= OUTPUT_WIDTH (possible only when OUTPUT_WIDTH is not a power of two): out_onehot=0, out_err=1, and the mask is not modified.
- Mask update, on accept, effective the next cycle:
  - in_accum=1: mask |= decode.
  - in_accum=0: mask = decode.
  - Erroring index: no change to the mask in either mode.
- Clear:
  - clear=1 with no accept: mask <= 0.
  - clear and accept in the same cycle: clear applies first, then the accepted decode. The mask ends equal to the decode, for either in_accum value.
- mask_count is registered and always consistent with mask in the same cycle. It equals OUTPUT_WIDTH when all bits are set; no wrap.
- in_index values are sampled only on accept. X on in_index while in_valid=0 has no effect.
- Reset mid-transfer drops the held item; there is no replay.
- Invariants (immediate assertions in RTL, checked when out_valid && !out_err):
  - out_onehot has exactly one bit set.
  - Priority-encoding out_onehot returns the accepted index.
  - mask_count == $countones(mask).

Decomposition:
- Package index_codec_pkg holds:
  - function onehot_decode(idx, width) -> {vector, err}
  - function popcount
- Sub-module index_decoder_accum_stage: the one-entry valid/ready output register, parameterised by payload width. It is reused later for the encoder side.
- Mask and count logic stay in the top module.

Test Plan:
- Reset then single accept, W=8: idx=5, in_accum=1 -> next cycle out_valid=1, out_onehot=8'b0010_0000, mask=8'b0010_0000, mask_count=1.
- Back-to-back stream with out_ready=1, W=8: idx 0,3,3,7 with in_accum=1 -> one output per cycle; final mask=8'b1000_1001, mask_count=3, in_ready stays 1 throughout.
- Backpressure: out_ready=0 for 3 cycles after idx=2 is accepted -> in_ready=0; out_onehot holds 8'b0000_0100; the second index is taken only in the cycle out_ready rises; no item is lost or duplicated.
- Out-of-range index, W=5: idx=6 -> out_err=1, out_onehot=0, mask unchanged. Then idx=4 -> out_onehot=5'b10000, out_err=0.
- Clear/replace interaction, W=8, mask=8'hFF:
  - clear=1 with idx=1 accepted -> mask=8'h02, count=1.
  - Then in_accum=0, idx=6 -> mask=8'h40.
- Async reset asserted while out_valid=1 and out_ready=0 -> all outputs are 0 immediately, without waiting for a clock edge. After release, in_ready=1. Repeat for W=2 (IDX_W=1) with idx 0 and 1 -> mask=2'b11, mask_count=2.
